// File: rtl/bin_a_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Captures a binary value on a start request and holds packed BCD digits for the display stage.

// One BCD digit's pre-shift correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decade.
module bin_a_bcd_ajuste (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);
  always_comb begin
    dig_o = dig_i;
    if (dig_i >= 4'd5) dig_o = dig_i + 4'd3;
  end
endmodule

module bin_a_bcd #(
  parameter int ANCHO   = 13,
  parameter int DIGITOS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inicio,
  input  logic [ANCHO-1:0]       binario,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   ocupado,
  output logic                   fin
);
  localparam int CW = $clog2(ANCHO + 1);
  localparam int BW = 4 * DIGITOS;

  typedef enum logic [1:0] {REPOSO, CONVIERTE, FIN} estado_t;

  estado_t         estado_q, estado_d;
  logic [ANCHO-1:0] bin_r_q, bin_r_d;
  logic [BW-1:0]    acum_q, acum_d;
  logic [CW-1:0]    cuenta_q, cuenta_d;
  logic [BW-1:0]    bcd_q, bcd_d;

  logic [BW-1:0]       acum_aj;
  logic [BW+ANCHO-1:0] desp;

  // Per-digit correction lanes feeding the shift.
  for (genvar g = 0; g < DIGITOS; g++) begin : g_dig
    bin_a_bcd_ajuste u_aj (
      .dig_i (acum_q[4*g +: 4]),
      .dig_o (acum_aj[4*g +: 4])
    );
  end

  // {adjusted acum, bin_r} shifted left by one; the MSB of acum_aj is always
  // zero after adjustment of a valid value, so it is dropped.
  assign desp = {acum_aj[BW-2:0], bin_r_q, 1'b0};

  always_comb begin
    estado_d = estado_q;
    bin_r_d  = bin_r_q;
    acum_d   = acum_q;
    cuenta_d = cuenta_q;
    bcd_d    = bcd_q;
    ocupado  = 1'b0;
    fin      = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          bin_r_d  = binario;
          acum_d   = '0;
          cuenta_d = CW'(ANCHO);
          estado_d = CONVIERTE;
        end
      end
      CONVIERTE: begin
        ocupado  = 1'b1;
        acum_d   = desp[BW+ANCHO-1:ANCHO];
        bin_r_d  = desp[ANCHO-1:0];
        cuenta_d = cuenta_q - 1'b1;
        if (cuenta_q == CW'(1)) begin
          bcd_d    = desp[BW+ANCHO-1:ANCHO];
          estado_d = FIN;
        end
      end
      FIN: begin
        fin      = 1'b1;
        estado_d = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= REPOSO;
      bin_r_q  <= '0;
      acum_q   <= '0;
      cuenta_q <= '0;
      bcd_q    <= '0;
    end else begin
      estado_q <= estado_d;
      bin_r_q  <= bin_r_d;
      acum_q   <= acum_d;
      cuenta_q <= cuenta_d;
      bcd_q    <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: tb/tb_bin_a_bcd.sv
// Self-checking bench for bin_a_bcd: scoreboard of expected BCD results and start cycles,
// compared whenever the DUT pulses fin.
module tb_bin_a_bcd;
  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [12:0] binario;
  logic [15:0] bcd;
  logic        ocupado;
  logic        fin;

  bin_a_bcd dut (
    .clk(clk), .rst(rst), .inicio(inicio), .binario(binario),
    .bcd(bcd), .ocupado(ocupado), .fin(fin)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] bcd; int start; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int fin_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: every fin pulse must match the oldest outstanding start.
  always @(negedge clk) begin
    if (fin) begin
      exp_t e;
      fin_cnt++;
      if (sb.size() == 0) chk("spurious_fin", 1, 0);
      else begin
        e = sb.pop_front();
        chk("bcd", bcd, e.bcd);
        chk("latency", cyc - e.start, 13);
      end
    end
  end

  task automatic push(input int v);
    exp_t e;
    e.bcd = to_bcd(v);
    e.start = cyc + 1;
    sb.push_back(e);
  endtask

  // One conversion from REPOSO; also counts ocupado cycles and returns to REPOSO.
  task automatic run_conv(input int v);
    int busy = 0;
    bit got = 0;
    @(negedge clk);
    binario = 13'(v); inicio = 1'b1; push(v);
    @(negedge clk);
    inicio = 1'b0;
    binario = 13'h1555;
    for (int i = 0; i < 30 && !got; i++) begin
      if (fin) got = 1;
      else begin
        if (ocupado) busy++;
        @(negedge clk);
      end
    end
    if (!got) chk("timeout_fin", 0, 1);
    chk("ocupado_cycles", busy, 13);
    @(negedge clk);
  endtask

  int fc0;
  int vals[4] = '{1, 2, 6, 24};

  initial begin
    rst = 1'b1; inicio = 1'b0; binario = '0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_fin", fin, 0);
    rst = 1'b0;

    run_conv(5040);
    chk("bcd_5040_hold", bcd, 16'h5040);
    run_conv(0);
    run_conv(8191);
    chk("bcd_8191_hold", bcd, 16'h8191);
    run_conv(1);
    run_conv(999);
    chk("bcd_999_hold", bcd, 16'h0999);

    // inicio during CONVIERTE and FIN is ignored
    fc0 = fin_cnt;
    @(negedge clk);
    binario = 13'd720; inicio = 1'b1; push(720);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      binario = 13'd24;
      inicio = (k == 4 || k == 13);
    end
    chk("ignored_fins", fin_cnt - fc0, 1);
    chk("ignored_sb_empty", sb.size(), 0);
    chk("bcd_720_hold", bcd, 16'h0720);

    // reset at shift 7 discards the conversion
    fc0 = fin_cnt;
    @(negedge clk);
    binario = 13'd5040; inicio = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      inicio = 1'b0;
      if (k == 6) rst = 1'b1;
    end
    @(negedge clk);
    chk("midrst_bcd", bcd, 16'h0000);
    chk("midrst_ocupado", ocupado, 0);
    chk("midrst_fin", fin, 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_nofin", fin_cnt - fc0, 0);
    run_conv(120);
    chk("bcd_120_hold", bcd, 16'h0120);

    // reset together with inicio: start lost
    fc0 = fin_cnt;
    @(negedge clk);
    rst = 1'b1; inicio = 1'b1; binario = 13'd77;
    @(negedge clk);
    rst = 1'b0; inicio = 1'b0;
    chk("rst_win_ocupado", ocupado, 0);
    repeat (16) @(negedge clk);
    chk("rst_win_nofin", fin_cnt - fc0, 0);

    // held inicio: a conversion every 15 cycles
    fc0 = fin_cnt;
    @(negedge clk);
    binario = 13'(vals[0]); inicio = 1'b1; push(vals[0]);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k % 15 == 14 && k < 45) begin
        binario = 13'(vals[k / 15 + 1]);
        push(vals[k / 15 + 1]);
      end
      if (k == 45) inicio = 1'b0;
    end
    chk("held_fins", fin_cnt - fc0, 4);
    chk("held_last_bcd", bcd, 16'h0024);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end
endmodule

// File: doc/bin_a_bcd.md
# bin_a_bcd

Sequential binary-to-BCD converter placed directly downstream of the factorial system. It captures the 13-bit `salida` result when that system raises `fin` (wired to `inicio` here). It converts the value to four packed BCD digits with the shift-and-add-3 (double-dabble) algorithm, one bit per clock, and holds the digits for the display stage. It adds no arithmetic to the upstream result; it only re-encodes it.

## Interface
- `ANCHO`, 13, width of the binary input; must satisfy 10^`DIGITOS` > 2^`ANCHO` − 1
- `DIGITOS`, 4, number of BCD digits produced
- `clk`  input  1  single system clock; all state updates on rising edge
- `rst`  input  1  reset, synchronous, active-high; overrides every other input
- `inicio`  input  1  start request; sampled only in state REPOSO
- `binario`  input  `ANCHO`  value to convert; captured on the accepted `inicio` edge only
- `bcd`  output  4·`DIGITOS`  packed BCD result; digit 0 (units) in bits [3:0], digit 3 in bits [15:12]; registered
- `ocupado`  output  1  high while a conversion is in progress
- `fin`  output  1  one-cycle pulse: `bcd` holds a new valid result

## Operation
- Internal registers:
  - `bin_r` (`ANCHO` bits), shift copy of the input
  - `acum` (4·`DIGITOS` bits), working BCD accumulator
  - `cuenta` (clog2(`ANCHO`+1) bits), remaining shifts
  - `bcd` output register
- FSM states: REPOSO, CONVIERTE, FIN.
- REPOSO:
  - `ocupado`=0, `fin`=0.
  - On `inicio`=1: `bin_r`←`binario`, `acum`←0, `cuenta`←`ANCHO`, next state CONVIERTE.
  - Otherwise stay.
- CONVIERTE, each cycle:
  - First form the adjusted accumulator: every 4-bit digit of `acum` ≥5 gets +3. Each digit's add is 4-bit and has no carry out, because the maximum is 9+3=12 before the shift.
  - Then shift {adjusted `acum`, `bin_r`} left by one. The MSB of `bin_r` enters bit 0 of `acum`; `bin_r` fills with 0.
  - `cuenta`←`cuenta`−1.
  - When `cuenta`=1 (last shift): load `bcd` with the shifted accumulator value, next state FIN.
  - `inicio` is ignored in this state.
- FIN:
  - `fin`=1, `ocupado`=0.
  - Next state REPOSO unconditionally.
  - `inicio` is ignored in FIN.
- `bcd` changes only on the last-shift edge or on reset. It holds its value through REPOSO until the next conversion completes.
- `binario` may change freely after capture without affecting the result.

## Timing
- Reset values: state REPOSO, `bcd`=0, `ocupado`=0, `fin`=0, `acum`=0, `bin_r`=0, `cuenta`=0.
- Let E0 be the edge where `inicio`=1 is sampled in REPOSO.
- Shifts occur on edges E1…E`ANCHO` (E1…E13 by default).
- `ocupado` is high from after E0 until E13.
- `bcd` takes its new value at E13.
- `fin` is high for exactly the one cycle between E13 and E14.
- Latency from the `inicio` sample to `fin` is 13 cycles.
- Earliest next accepted `inicio` is at E15, since E14 only moves FIN to REPOSO. Minimum period is 15 cycles per conversion.
- A held-high `inicio` restarts a conversion on every REPOSO visit, using the `binario` value present at each accept edge.
- `rst`=1 on any edge, including mid-CONVIERTE or FIN:
  - Forces all reset values on that edge.
  - The partial result is discarded, `fin` is not pulsed, and `bcd` is cleared.
- `rst` and `inicio` asserted together: reset wins; the start is lost.

## Test plan
- Reset, then `binario`=5040 with a one-cycle `inicio` → `ocupado` high for 13 cycles, then `fin` pulses once and `bcd`=16'h5040 (7! from upstream).
- Boundary values, one conversion each:
  - `binario`=0 → `bcd`=16'h0000, `fin` after 13 cycles.
  - `binario`=8191 → `bcd`=16'h8191.
  - `binario`=1 → `bcd`=16'h0001.
  - `binario`=999 → `bcd`=16'h0999.
- Start `binario`=720, change `binario` to 24 and pulse `inicio` at cycles 5 and 13 (in FIN) → exactly one `fin` pulse, `bcd`=16'h0720, no second conversion.
- `rst` asserted at shift 7 of a conversion of 5040 → next cycle `bcd`=0, `ocupado`=0, no `fin`. A following `inicio` with 120 → `bcd`=16'h0120 after 13 cycles.
- `inicio` held high with `binario` stepping 1, 2, 6, 24 at each accept edge → a `fin` pulse every 15 cycles; `bcd` sequence 0001, 0002, 0006, 0024.
